// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// the decode from a state to the reset levels it implies.
package reset_seq_pkg;

  localparam int STATE_W = 3;

  // Encodings 5-7 are never produced. If one appears anyway, the FSM returns to S_RESET.
  typedef enum logic [STATE_W-1:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_HOLD      = 3'd2,
    S_STAGGER   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  // Peripherals are released first, on entry to S_STAGGER.
  function automatic logic periph_reset_of(state_t s);
    return !((s == S_STAGGER) || (s == S_RUN));
  endfunction

  // The core is released only in S_RUN. It is also "idle" in every other state.
  function automatic logic core_reset_of(state_t s);
    return (s != S_RUN);
  endfunction

endpackage

// File: rtl/debouncer.sv
// Push-button conditioner. It takes the raw, bouncy, active-low button and
// synchronises it. It then filters it to a debounced level and emits a one-cycle
// press pulse when that level goes from 1 to 0.
module debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int CNT_W           = 17
) (
  input  logic clock,
  input  logic N_RESET,
  input  logic button_raw,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  logic                   level_q;
  logic                   press_q;
  logic [CNT_W-1:0]       cnt_q;

  assign sample = sync_q[SYNC_STAGES-1];
  assign press  = press_q;

  // Synchronizer chain. The button is released (1) during reset, so coming
  // out of reset never looks like a press.
  always_ff @(posedge clock or negedge N_RESET) begin
    if (!N_RESET) begin
      sync_q <= '1;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what makes this a real shift chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_raw};
    end
  end

  // Debounce counter. The level follows the sample only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles. The press pulse is raised
  // on the same edge that the level falls.
  always_ff @(posedge clock or negedge N_RESET) begin
    if (!N_RESET) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (sample == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sample;
        cnt_q   <= '0;
        press_q <= ~sample;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Board-level reset sequencer. It turns the raw N_RESET pin, the PLL lock flag
// and the user push-button into staged, synchronous resets. Peripherals are
// released first, and the core is released STAGGER_CYCLES later. It also
// provides an idle flag and a state code for the status LEDs.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES        = 16,
  parameter int STAGGER_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES    = 65536,
  parameter int CNT_W              = 17
) (
  input  logic               clock,
  input  logic               N_RESET,
  input  logic               pllLock,
  input  logic               softResetButton,
  output logic               periphReset,
  output logic               coreReset,
  output logic               idle,
  output logic [STATE_W-1:0] state
);

  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   rst_ok;
  logic                   lock_ok;
  logic                   press;

  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   periph_q;
  logic                   core_q;

  assign rst_ok  = rst_sync_q[SYNC_STAGES-1];
  assign lock_ok = lock_sync_q[SYNC_STAGES-1];

  // Reset-release chain. It is cleared asynchronously and fills with 1s, so
  // the FSM only leaves S_RESET a fixed number of clean edges after N_RESET rises.
  always_ff @(posedge clock or negedge N_RESET) begin
    if (!N_RESET) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // PLL lock synchronizer. Lock is treated as absent until it has been seen
  // through the full chain.
  always_ff @(posedge clock or negedge N_RESET) begin
    if (!N_RESET) begin
      lock_sync_q <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pllLock};
    end
  end

  debouncer #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debouncer (
    .clock      (clock),
    .N_RESET    (N_RESET),
    .button_raw (softResetButton),
    .press      (press)
  );

  // State and shared phase counter.
  always_ff @(posedge clock or negedge N_RESET) begin
    if (!N_RESET) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The case handles the normal progression and counter
  // expiry. The override afterwards applies lock loss and then button press,
  // so those take precedence over expiry.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_RESET: begin
        cnt_d = '0;
        if (rst_ok) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (!lock_ok) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_STAGGER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STAGGER: begin
        if (cnt_q == STAGGER_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase

    // Once lock has been qualified, losing it sends us back to requalify.
    // A button press restarts the hold period. Presses are ignored before
    // lock is qualified.
    if ((state_q == S_HOLD) || (state_q == S_STAGGER) || (state_q == S_RUN)) begin
      if (!lock_ok) begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
      end else if (press) begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    end
  end

  // Reset outputs are registered from the next state. They change on the same
  // edge as the state and are always glitch-free.
  always_ff @(posedge clock or negedge N_RESET) begin
    if (!N_RESET) begin
      periph_q <= 1'b1;
      core_q   <= 1'b1;
    end else begin
      periph_q <= periph_reset_of(state_d);
      core_q   <= core_reset_of(state_d);
    end
  end

  assign periphReset = periph_q;
  assign coreReset   = core_q;
  assign idle        = core_q;
  assign state       = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer. A behavioural reference model
// tracks run lengths of synchronised lock and button samples and the time
// spent in each phase. The stimulus is randomised.
module tb_reset_sequencer;

  localparam int L    = 8;
  localparam int H    = 4;
  localparam int S    = 2;
  localparam int DEB  = 3;
  localparam int SYNC = 2;

  logic       clock = 1'b0;
  logic       N_RESET = 1'b0;
  logic       pllLock = 1'b0;
  logic       softResetButton = 1'b1;
  logic       periphReset;
  logic       coreReset;
  logic       idle;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model state
  int m_state;
  int m_run;
  int m_since_rst;
  int m_diff;
  bit m_level;
  bit m_press;
  bit lock_q[$];
  bit btn_q[$];

  always #5 clock = ~clock;

  reset_sequencer #(
    .SYNC_STAGES        (SYNC),
    .LOCK_STABLE_CYCLES (L),
    .HOLD_CYCLES        (H),
    .STAGGER_CYCLES     (S),
    .DEBOUNCE_CYCLES    (DEB),
    .CNT_W              (17)
  ) dut (
    .clock           (clock),
    .N_RESET         (N_RESET),
    .pllLock         (pllLock),
    .softResetButton (softResetButton),
    .periphReset     (periphReset),
    .coreReset       (coreReset),
    .idle            (idle),
    .state           (state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] obs();
    return {periphReset, coreReset, idle, state};
  endfunction

  function automatic logic [5:0] exp_vec();
    logic p;
    logic c;
    p = (m_state <= 2);
    c = (m_state != 4);
    return {p, c, c, 3'(m_state)};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_run = 0;
    m_since_rst = 0;
    m_diff = 0;
    m_level = 1'b1;
    m_press = 1'b0;
    lock_q = {};
    btn_q = {};
    for (int i = 0; i < SYNC; i++) begin
      lock_q.push_back(1'b0);
      btn_q.push_back(1'b1);
    end
    edge_n = 0;
  endtask

  // One clock edge of the reference model. lk and bt are the pin values
  // sampled at this edge. They reach the control logic SYNC edges later.
  task automatic model_edge(input bit lk_pin, input bit bt_pin);
    bit lk;
    bit bt;
    bit new_press;
    lk = lock_q[0];
    bt = btn_q[0];
    new_press = 1'b0;
    if (m_state == 0) begin
      if (m_since_rst >= SYNC) m_state = 1;
    end else if (m_state == 1) begin
      if (lk) begin
        m_run++;
        if (m_run == L) begin m_state = 2; m_run = 0; end
      end else begin
        m_run = 0;
      end
    end else if (!lk) begin
      m_state = 1;
      m_run = 0;
    end else if (m_press) begin
      m_state = 2;
      m_run = 0;
    end else if (m_state != 4) begin
      m_run++;
      if (m_state == 2 && m_run == H) begin m_state = 3; m_run = 0; end
      else if (m_state == 3 && m_run == S) begin m_state = 4; m_run = 0; end
    end
    if (bt != m_level) begin
      m_diff++;
      if (m_diff == DEB) begin
        m_level = bt;
        m_diff = 0;
        new_press = !bt;
      end
    end else begin
      m_diff = 0;
    end
    m_press = new_press;
    void'(lock_q.pop_front());
    lock_q.push_back(lk_pin);
    void'(btn_q.pop_front());
    btn_q.push_back(bt_pin);
    m_since_rst++;
    edge_n++;
  endtask

  task automatic tick(input bit lk, input bit bt);
    pllLock = lk;
    softResetButton = bt;
    @(posedge clock);
    model_edge(lk, bt);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    N_RESET = 1'b0;
    pllLock = 1'b1;
    softResetButton = 1'b1;
    repeat (2) @(negedge clock);
    model_reset();
    N_RESET = 1'b1;
  endtask

  task automatic test_reset();
    int w;
    int p;
    int c;
    int seq[$];
    bit ok;
    @(negedge clock);
    N_RESET = 1'b0;
    pllLock = 1'b1;
    softResetButton = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (obs() !== 6'b111000) begin
        errors++;
        $display("FAIL reset_hold: got %b expected %b", obs(), 6'b111000);
      end
    end
    model_reset();
    N_RESET = 1'b1;
    w = -1; p = -1; c = -1;
    seq.push_back(int'(state));
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b1);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_seq edge %0d: got %b expected %b", edge_n, obs(), exp_vec());
      end
      if (int'(state) != seq[$]) seq.push_back(int'(state));
      if (w < 0 && state === 3'd1) w = edge_n;
      if (p < 0 && periphReset === 1'b0) p = edge_n;
      if (c < 0 && coreReset === 1'b0) c = edge_n;
    end
    checks++;
    if (p - w != L + H) begin
      errors++;
      $display("FAIL periph_release: got %0d edges expected %0d", p - w, L + H);
    end
    checks++;
    if (c - w != L + H + S) begin
      errors++;
      $display("FAIL core_release: got %0d edges expected %0d", c - w, L + H + S);
    end
    checks++;
    if (c != SYNC + L + H + S + 1) begin
      errors++;
      $display("FAIL release_latency: got edge %0d expected %0d", c, SYNC + L + H + S + 1);
    end
    ok = (seq.size() == 5);
    for (int k = 0; k < seq.size() && k < 5; k++) ok &= (seq[k] == k);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL state_walk: got %0d distinct steps expected 0,1,2,3,4", seq.size());
    end
  endtask

  task automatic test_lock_glitch();
    int d;
    int h;
    do_reset();
    d = $urandom_range(8, 3);
    h = -1;
    for (int i = 0; i < 40; i++) begin
      tick((i + 1) != d, 1'b1);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL lock_glitch edge %0d: got %b expected %b", edge_n, obs(), exp_vec());
      end
      if (h < 0 && state === 3'd2) h = edge_n;
    end
    checks++;
    if (h != d + SYNC + L) begin
      errors++;
      $display("FAIL lock_requalify: hold at edge %0d expected %0d", h, d + SYNC + L);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    int k;
    int r;
    int c;
    int low_len;
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL lock_loss_start: got state %0d expected 4", state);
    end
    n = $urandom_range(5, 0);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1);
    k = edge_n + 1;
    low_len = $urandom_range(6, 3);
    for (int i = 0; i < low_len; i++) begin
      tick(1'b0, 1'b1);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL lock_loss edge %0d: got %b expected %b", edge_n, obs(), exp_vec());
      end
      if (edge_n == k + 1) begin
        checks++;
        if (state !== 3'd4) begin
          errors++;
          $display("FAIL lock_loss_early: got state %0d expected 4", state);
        end
      end
      if (edge_n == k + 2) begin
        checks++;
        if (obs() !== 6'b111001) begin
          errors++;
          $display("FAIL lock_loss_react: got %b expected %b", obs(), 6'b111001);
        end
      end
    end
    r = edge_n + 1;
    c = -1;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b1);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL relock edge %0d: got %b expected %b", edge_n, obs(), exp_vec());
      end
      if (c < 0 && coreReset === 1'b0) c = edge_n;
    end
    checks++;
    if (c != r + SYNC + L + H + S - 1) begin
      errors++;
      $display("FAIL relock_latency: core released at edge %0d expected %0d", c, r + SYNC + L + H + S - 1);
    end
  endtask

  task automatic test_button_bounce();
    bit ph;
    bit bt;
    int presses;
    int core_hi;
    logic [2:0] prev;
    ph = 1'($urandom_range(1, 0));
    presses = 0;
    core_hi = 0;
    for (int i = 0; i < 35; i++) begin
      if (i < 10) bt = ph ^ 1'(i & 1);
      else if (i < 15) bt = 1'b0;
      else bt = 1'b1;
      prev = state;
      tick(1'b1, bt);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL bounce edge %0d: got %b expected %b", edge_n, obs(), exp_vec());
      end
      if (prev === 3'd4 && state === 3'd2) presses++;
      if (coreReset === 1'b1) core_hi++;
    end
    checks++;
    if (presses != 1) begin
      errors++;
      $display("FAIL bounce_presses: got %0d expected 1", presses);
    end
    checks++;
    if (core_hi != H + S) begin
      errors++;
      $display("FAIL bounce_core_hold: got %0d cycles expected %0d", core_hi, H + S);
    end
    checks++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL bounce_return: got state %0d expected 4", state);
    end
  endtask

  task automatic test_button_states();
    int h;
    int restarts;
    int e;
    bit bt;
    logic [2:0] prev;
    do_reset();
    h = -1;
    restarts = 0;
    for (int i = 0; i < 30; i++) begin
      e = i + 1;
      bt = !((e >= 3 && e <= 5) || (e >= 11 && e <= 14));
      prev = state;
      tick(1'b1, bt);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL button_states edge %0d: got %b expected %b", edge_n, obs(), exp_vec());
      end
      if (h < 0 && state === 3'd2) h = edge_n;
      if (prev === 3'd3 && state === 3'd2 && periphReset === 1'b1) restarts++;
    end
    checks++;
    if (h != SYNC + 1 + L) begin
      errors++;
      $display("FAIL press_in_wait_lock: hold at edge %0d expected %0d", h, SYNC + 1 + L);
    end
    checks++;
    if (restarts != 1) begin
      errors++;
      $display("FAIL press_in_stagger: got %0d restarts expected 1", restarts);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1'b1, 1'b1);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL async_lead edge %0d: got %b expected %b", edge_n, obs(), exp_vec());
      end
      if (state === 3'd3) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL async_reach_stagger: got state %0d expected 3", state);
    end
    #1 N_RESET = 1'b0;
    #1;
    checks++;
    if (obs() !== 6'b111000) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", obs(), 6'b111000);
    end
    @(negedge clock);
    checks++;
    if (obs() !== 6'b111000) begin
      errors++;
      $display("FAIL async_reset_held: got %b expected %b", obs(), 6'b111000);
    end
  endtask

  task automatic test_random();
    bit lk;
    bit bt;
    int lk_left;
    int bt_left;
    do_reset();
    lk = 1'b1;
    bt = 1'b1;
    lk_left = 30;
    bt_left = 10;
    for (int i = 0; i < 600; i++) begin
      if (lk_left == 0) begin
        lk = !lk;
        lk_left = lk ? $urandom_range(80, 20) : $urandom_range(4, 1);
      end
      if (bt_left == 0) begin
        bt = 1'($urandom_range(1, 0));
        bt_left = $urandom_range(6, 1);
      end
      lk_left--;
      bt_left--;
      tick(lk, bt);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL random edge %0d: got %b expected %b", edge_n, obs(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_glitch();
    test_lock_loss();
    test_button_bounce();
    test_button_states();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
